// File: rtl/round_robin_address_encoder.sv
// Round-robin request encoder that drives the 3-to-8 address decoder.
// Eight request lines are arbitrated round-robin. The winner's index is
// presented on adr0/adr1/adr2 (MSB..LSB) with a select strobe. The grant is
// held until ack arrives, or until the watchdog expires.
//
// state | meaning
// IDLE  | select low, adr holds last value, arbitrating pending requests
// GRANT | select high, adr frozen, waiting for ack or watchdog expiry
module round_robin_address_encoder #(
  parameter int N_REQ   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_x,
  input  logic       ack,
  output logic       adr0,
  output logic       adr1,
  output logic       adr2,
  output logic       select,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Watchdog fires on the last cycle of a TIMEOUT-long grant window.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       select_q, select_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [2:0] pick;
  logic [2:0] cand;

  // Search ptr+1, ptr+2, ... wrapping; the just-served index comes last.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && req_x[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    select_d  = select_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          idx_d    = pick;
          select_d = 1'b1;
          cnt_d    = 8'd0;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d  = IDLE;
          select_d = 1'b0;
          ptr_d    = idx_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          select_d  = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = idx_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears select at once, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd7;
      idx_q     <= 3'd0;
      cnt_q     <= 8'd0;
      select_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      select_q  <= select_d;
      timeout_q <= timeout_d;
    end
  end

  assign adr0    = idx_q[2];
  assign adr1    = idx_q[1];
  assign adr2    = idx_q[0];
  assign select  = select_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_round_robin_address_encoder.sv
// Directed bench for round_robin_address_encoder (TIMEOUT = 16).
module tb_round_robin_address_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_x;
  logic       ack;
  logic       adr0, adr1, adr2;
  logic       select;
  logic       timeout;

  int n_checks;
  int n_fail;

  round_robin_address_encoder #(.N_REQ(8), .TIMEOUT(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_x  (req_x),
    .ack    (ack),
    .adr0   (adr0),
    .adr1   (adr1),
    .adr2   (adr2),
    .select (select),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int adr_val();
    return int'({adr0, adr1, adr2});
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req_x    = 8'hFF;
    ack      = 1'b0;

    // Reset with every request pending.
    tick();
    tick();
    check_val("rst_select", int'(select), 0);
    check_val("rst_adr", adr_val(), 0);
    check_val("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    tick();
    check_val("first_select", int'(select), 1);
    check_val("first_adr", adr_val(), 0);

    // Round robin with all requests held and immediate ack.
    ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_val($sformatf("rr_gap%0d", i), int'(select), 0);
      tick();
      check_val($sformatf("rr_sel%0d", i), int'(select), 1);
      check_val($sformatf("rr_adr%0d", i), adr_val(), i % 8);
    end
    req_x = 8'h00;
    tick();
    check_val("rr_end_sel", int'(select), 0);
    ack = 1'b0;

    // Single request for unit 5.
    req_x = 8'b0010_0000;
    tick();
    check_val("single_sel", int'(select), 1);
    check_val("single_adr0", int'(adr0), 1);
    check_val("single_adr1", int'(adr1), 0);
    check_val("single_adr2", int'(adr2), 1);
    ack   = 1'b1;
    req_x = 8'h00;
    tick();
    check_val("single_rel", int'(select), 0);
    check_val("single_hold_adr", adr_val(), 5);
    ack = 1'b0;
    tick();
    check_val("idle_ack_ignored", int'(select), 0);

    // Priority rotation after serving 5: expect 0, then 2, then 5.
    req_x = 8'b0010_0101;
    ack   = 1'b1;
    tick();
    check_val("rot_adr_a", adr_val(), 0);
    check_val("rot_sel_a", int'(select), 1);
    tick();
    tick();
    check_val("rot_adr_b", adr_val(), 2);
    tick();
    tick();
    check_val("rot_adr_c", adr_val(), 5);
    req_x = 8'h00;
    tick();
    ack = 1'b0;
    check_val("rot_end_sel", int'(select), 0);

    // Watchdog: request 3, no ack, request withdrawn during the grant.
    req_x = 8'h08;
    tick();
    check_val("to_sel_start", int'(select), 1);
    check_val("to_adr_start", adr_val(), 3);
    req_x = 8'h40;
    for (int k = 2; k <= 16; k++) begin
      tick();
      check_val($sformatf("to_sel_c%0d", k), int'(select), 1);
      check_val($sformatf("to_to_c%0d", k), int'(timeout), 0);
    end
    check_val("to_adr_frozen", adr_val(), 3);
    req_x = 8'h00;
    tick();
    check_val("to_sel_rel", int'(select), 0);
    check_val("to_pulse", int'(timeout), 1);
    tick();
    check_val("to_pulse_end", int'(timeout), 0);
    check_val("to_idle_sel", int'(select), 0);

    // ack coincides with the watchdog's final cycle: ack wins.
    req_x = 8'h08;
    tick();
    check_val("ackto_sel", int'(select), 1);
    check_val("ackto_adr", adr_val(), 3);
    req_x = 8'h00;
    for (int k = 2; k <= 16; k++) tick();
    check_val("ackto_sel_last", int'(select), 1);
    ack = 1'b1;
    tick();
    check_val("ackto_rel", int'(select), 0);
    check_val("ackto_no_pulse", int'(timeout), 0);
    ack = 1'b0;
    tick();
    check_val("ackto_no_pulse2", int'(timeout), 0);

    // Async reset during a grant; ptr was 3 so request 1 wins.
    req_x = 8'h02;
    tick();
    check_val("ar_sel", int'(select), 1);
    check_val("ar_adr", adr_val(), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_sel_async", int'(select), 0);
    check_val("ar_adr_async", adr_val(), 0);
    req_x = 8'h81;
    #1;
    rst_n = 1'b1;
    tick();
    // Pointer back at 7: index 0 wins over 7.
    check_val("ar_ptr_sel", int'(select), 1);
    check_val("ar_ptr_adr", adr_val(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_address_encoder.md
Name: round_robin_address_encoder

Overview:
- Request-side counterpart of the 3-to-8 address decoder: encodes 8 one-per-line requests into the 3-bit address plus `select` strobe that drive the decoder.
- Arbitrates among simultaneous requesters round-robin and holds the grant until the addressed unit acknowledges.
- A watchdog releases the grant on a missing acknowledge.
- Sits between the requester units and the decoder input (adr0/adr1/adr2/select).

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 to match the 3-bit address.
- TIMEOUT, 16, max cycles `select` stays high without `ack` before forced release; legal range 2..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_x  input  8  request lines; bit i requests unit i; level-sensitive.
- ack  input  1  addressed unit done; sampled only while select=1.
- adr0  output  1  address MSB (index bit 2).
- adr1  output  1  address bit 1.
- adr2  output  1  address LSB (index bit 0).
- select  output  1  grant strobe to decoder enable.
- timeout  output  1  one-cycle pulse on watchdog release.

Behaviour:
- Address mapping: granted index i -> adr0=i[2], adr1=i[1], adr2=i[0].
  - This is the decoder's convention: sel_x[i] is active for that pattern.
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - select=0, timeout=0, adr0/adr1/adr2=000.
  - state=IDLE, last-grant pointer=7 (first search starts at index 0), watchdog count=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, GRANT.
- IDLE:
  - req_x==0: stay in IDLE; adr holds its previous value; select=0.
  - req_x!=0: pick the first set bit searching ptr+1, ptr+2, … mod 8.
  - At the next edge: latch that index onto adr, select=1, count=0, go to GRANT.
  - Latency from request to select is 1 cycle.
- GRANT:
  - adr is frozen; req_x changes (including withdrawal of the granted request) are ignored.
  - ack=1: next edge select=0, ptr=granted index, go to IDLE.
  - ack=0 and count==TIMEOUT-1: next edge select=0, timeout=1 for one cycle, ptr=granted index, go to IDLE.
  - Otherwise count increments.
  - If ack=1 arrives in the same cycle as the timeout condition, ack wins and no timeout pulse is generated.
- Back-to-back grants: at least one IDLE cycle between grants; select is low for ≥1 cycle between grants.
  - A continuously requesting single unit is granted every 2 cycles when ack is immediate.
- Fairness: the just-served index has the lowest priority in the next arbitration.
  - With all 8 requests held, grants cycle 0,1,…,7,0.
- ack while in IDLE is ignored.
- Reset mid-GRANT: select drops immediately and asynchronously; the pointer returns to 7.

Test Plan:
- Reset: rst_n=0 with req_x=8'hFF → select=0, adr=000, timeout=0; release reset → 1 cycle later select=1, adr0..2=000 (index 0).
- Single request: req_x=8'b0010_0000 in IDLE → next edge adr0/adr1/adr2=1/0/1, select=1; ack=1 for one cycle → select=0 next edge.
- Round-robin: req_x=8'hFF held, ack tied 1 → grant index sequence 0,1,2,…,7,0 with select toggling 1,0,1,0.
- Priority rotation: grant 5 completes; then req_x=8'b0010_0101 → next grant index 0, then index 2, then 5.
- Timeout: TIMEOUT=16, req_x=8'h08, ack=0 → select high exactly 16 cycles, then select=0 with a one-cycle timeout pulse; the next grant goes to 3 only if no other requester is active.
- Robustness:
  - Granted request withdrawn mid-GRANT → adr and select unchanged until ack.
  - ack and timeout in the same cycle → timeout stays 0.
  - Async reset asserted mid-GRANT → select=0 without waiting for a clock edge.
